// File: rtl/score_controller.sv
`default_nettype none
// ============================================================================
//  Module      : score_controller
//  Description : Game-level sequencer for the 4-digit BCD HUD score.
//                Owns the score tick prescaler, the BCD score register, the
//                high-score register and the game-over blink timer.
//                Flow: IDLE -> RUNNING (start) -> GAME_OVER (hit) -> IDLE.
//  Ports       : clock       - system clock
//                reset       - asynchronous active-high reset
//                start       - start button level, acts only in IDLE
//                hit         - collision flag level, acts only in RUNNING
//                disp_value  - BCD {thousands,hundreds,tens,units}
//                disp_enable - digit renderers visible (blink control)
//                running     - high while in RUNNING
//                new_record  - last finished game beat the previous high
//                game_state  - 00 IDLE, 01 RUNNING, 10 GAME_OVER
//  Revision    : 1.0 - initial release
// ============================================================================
module score_controller #(
   parameter int TICK_DIV     = 20000000,
   parameter int BLINK_DIV    = 12500000,
   parameter int FLASH_PHASES = 6
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        hit,
   output logic [15:0] disp_value,
   output logic        disp_enable,
   output logic        running,
   output logic        new_record,
   output logic [1:0]  game_state
);

   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int BW = $clog2(BLINK_DIV + 1);
   localparam int FW = $clog2(FLASH_PHASES + 1);

   localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] C_BLINK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [FW-1:0] C_PHASE_LAST = FW'(FLASH_PHASES - 1);
   localparam logic [15:0]   C_SCORE_MAX  = 16'h9999;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_OVER = 2'b10,
      ST_BAD  = 2'b11
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [15:0]   r_score, w_score_nxt;
   logic [15:0]   r_high,  w_high_nxt;
   logic [PW-1:0] r_presc, w_presc_nxt;
   logic [BW-1:0] r_blink, w_blink_nxt;
   logic [FW-1:0] r_phase, w_phase_nxt;
   logic          r_en,    w_en_nxt;
   logic          r_rec,   w_rec_nxt;
   logic [15:0]   r_disp,  w_disp_nxt;
   logic          r_running, w_running_nxt;

   // Ripple the carry from units towards thousands.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] res;
      logic        carry;
      res   = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (res[4*i +: 4] == 4'd9) begin
               res[4*i +: 4] = 4'd0;
            end else begin
               res[4*i +: 4] = res[4*i +: 4] + 4'd1;
               carry         = 1'b0;
            end
         end
      end
      return res;
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_score_nxt = r_score;
      w_high_nxt  = r_high;
      w_presc_nxt = r_presc;
      w_blink_nxt = r_blink;
      w_phase_nxt = r_phase;
      w_en_nxt    = r_en;
      w_rec_nxt   = r_rec;
      case (r_state)
         ST_IDLE: begin
            // start wins over hit; hit has no meaning here
            if (start) begin
               w_state_nxt = ST_RUN;
               w_score_nxt = 16'h0000;
               w_presc_nxt = '0;
               w_rec_nxt   = 1'b0;
            end
         end
         ST_RUN: begin
            if (hit) begin
               // Hit suppresses a coincident tick and freezes the prescaler.
               // BCD digits are ordered by weight, so a plain unsigned
               // compare is a valid magnitude compare.
               w_state_nxt = ST_OVER;
               if (r_score > r_high) begin
                  w_high_nxt = r_score;
                  w_rec_nxt  = 1'b1;
               end
               w_blink_nxt = '0;
               w_phase_nxt = '0;
               w_en_nxt    = 1'b0;
            end else if (r_presc == C_PRESC_LAST) begin
               w_presc_nxt = '0;
               if (r_score != C_SCORE_MAX) begin
                  w_score_nxt = bcd_inc(r_score);
               end
            end else begin
               w_presc_nxt = r_presc + 1'b1;
            end
         end
         ST_OVER: begin
            if (r_blink == C_BLINK_LAST) begin
               w_blink_nxt = '0;
               w_en_nxt    = ~r_en;
               if (r_phase == C_PHASE_LAST) begin
                  w_state_nxt = ST_IDLE;
                  w_phase_nxt = '0;
                  w_en_nxt    = 1'b1;
               end else begin
                  w_phase_nxt = r_phase + 1'b1;
               end
            end else begin
               w_blink_nxt = r_blink + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_en_nxt    = 1'b1;
         end
      endcase
      // Outputs are registered, so derive them from the next-state values.
      w_disp_nxt    = (w_state_nxt == ST_IDLE) ? w_high_nxt : w_score_nxt;
      w_running_nxt = (w_state_nxt == ST_RUN);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_score   <= 16'h0000;
         r_high    <= 16'h0000;
         r_presc   <= '0;
         r_blink   <= '0;
         r_phase   <= '0;
         r_en      <= 1'b1;
         r_rec     <= 1'b0;
         r_disp    <= 16'h0000;
         r_running <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_score   <= w_score_nxt;
         r_high    <= w_high_nxt;
         r_presc   <= w_presc_nxt;
         r_blink   <= w_blink_nxt;
         r_phase   <= w_phase_nxt;
         r_en      <= w_en_nxt;
         r_rec     <= w_rec_nxt;
         r_disp    <= w_disp_nxt;
         r_running <= w_running_nxt;
      end
   end

   assign disp_value  = r_disp;
   assign disp_enable = r_en;
   assign running     = r_running;
   assign new_record  = r_rec;
   assign game_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_score_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_controller
//  Description : Self-checking bench for score_controller with a decimal
//                behavioural model and a per-cycle compare process.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_controller;

   localparam int TICK_DIV     = 4;
   localparam int BLINK_DIV    = 3;
   localparam int FLASH_PHASES = 4;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic        hit   = 1'b0;
   logic [15:0] disp_value;
   logic        disp_enable;
   logic        running;
   logic        new_record;
   logic [1:0]  game_state;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   score_controller #(
      .TICK_DIV    (TICK_DIV),
      .BLINK_DIV   (BLINK_DIV),
      .FLASH_PHASES(FLASH_PHASES)
   ) u_dut (
      .clock      (clk),
      .reset      (rst),
      .start      (start),
      .hit        (hit),
      .disp_value (disp_value),
      .disp_enable(disp_enable),
      .running    (running),
      .new_record (new_record),
      .game_state (game_state)
   );

   // ---------------- behavioural model (decimal integers) ----------------
   int m_mode;   // 0 idle, 1 running, 2 game over
   int m_score;
   int m_high;
   int m_cnt;    // cycles spent in the current running / game-over period
   int m_rec;
   int m_en;

   function automatic logic [15:0] to_bcd(input int v);
      return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_mode <= 0; m_score <= 0; m_high <= 0; m_cnt <= 0; m_rec <= 0; m_en <= 1;
      end else begin
         case (m_mode)
            0: if (start) begin
                  m_mode <= 1; m_score <= 0; m_cnt <= 0; m_rec <= 0;
               end
            1: if (hit) begin
                  if (m_score > m_high) begin
                     m_high <= m_score; m_rec <= 1;
                  end
                  m_mode <= 2; m_cnt <= 0; m_en <= 0;
               end else begin
                  m_cnt <= m_cnt + 1;
                  if ((m_cnt + 1) % TICK_DIV == 0)
                     m_score <= (m_score < 9999) ? m_score + 1 : 9999;
               end
            default: begin
               m_cnt <= m_cnt + 1;
               if (m_cnt + 1 >= BLINK_DIV * FLASH_PHASES) begin
                  m_mode <= 0; m_en <= 1;
               end else begin
                  m_en <= ((m_cnt + 1) / BLINK_DIV) % 2;
               end
            end
         endcase
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("disp_value", int'(disp_value), int'(to_bcd(m_mode == 0 ? m_high : m_score)));
         chk("disp_enable", int'(disp_enable), m_en);
         chk("running", int'(running), (m_mode == 1) ? 1 : 0);
         chk("new_record", int'(new_record), m_rec);
         chk("game_state", int'(game_state), m_mode);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 60; i++) begin
         if (game_state == 2'b00) break;
         tick();
      end
      chk("idle_reached", int'(game_state), 0);
   endtask

   // start, m running cycles, then a hit
   task automatic run_game(input int m);
      start = 1'b1; tick(); start = 1'b0;
      repeat (m) tick();
      hit = 1'b1; tick(); hit = 1'b0;
      wait_idle();
   endtask

   task automatic check_reset_now(input string tag);
      rst = 1'b1;
      #1;
      chk({tag, "_state"}, int'(game_state), 0);
      chk({tag, "_disp"},  int'(disp_value), 0);
      chk({tag, "_en"},    int'(disp_enable), 1);
      chk({tag, "_rec"},   int'(new_record), 0);
      chk({tag, "_run"},   int'(running), 0);
      tick();
      rst = 1'b0;
      tick();
   endtask

   int pat[12] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};

   initial begin
      #1;
      rst = 1'b1;
      #1;
      chk_en = 1'b1;
      chk("rst_disp", int'(disp_value), 0);
      chk("rst_en", int'(disp_enable), 1);
      tick();
      rst = 1'b0;
      tick();

      // Game A: count to 0x0012, then reset mid-run
      start = 1'b1; tick(); start = 1'b0;
      chk("a_state", int'(game_state), 1);
      chk("a_running", int'(running), 1);
      chk("a_disp0", int'(disp_value), 16'h0000);
      repeat (48) tick();
      chk("a_disp12", int'(disp_value), 16'h0012);
      check_reset_now("rstA");

      // Game B: hit on terminal count at score 7, start held during flash
      start = 1'b1; tick(); start = 1'b0;
      repeat (31) tick();
      hit = 1'b1; tick(); hit = 1'b0;
      chk("b_state", int'(game_state), 2);
      chk("b_disp", int'(disp_value), 16'h0007);
      chk("b_rec", int'(new_record), 1);
      start = 1'b1;
      for (int i = 0; i < 12; i++) begin
         chk("b_blink", int'(disp_enable), pat[i]);
         chk("b_over", int'(game_state), 2);
         if (i == 8) start = 1'b0;
         tick();
      end
      chk("b_idle", int'(game_state), 0);
      chk("b_idle_en", int'(disp_enable), 1);
      chk("b_high", int'(disp_value), 16'h0007);

      run_game(20);
      chk("c_rec", int'(new_record), 0);
      chk("c_high", int'(disp_value), 16'h0007);
      run_game(28);
      chk("d_rec_equal", int'(new_record), 0);
      chk("d_high", int'(disp_value), 16'h0007);
      run_game(32);
      chk("e_rec", int'(new_record), 1);
      chk("e_high", int'(disp_value), 16'h0008);

      // Reset mid-run at score 3
      start = 1'b1; tick(); start = 1'b0;
      repeat (13) tick();
      chk("f_disp3", int'(disp_value), 16'h0003);
      check_reset_now("rstRun");

      // Reset mid game-over
      start = 1'b1; tick(); start = 1'b0;
      repeat (10) tick();
      hit = 1'b1; tick(); hit = 1'b0;
      repeat (4) tick();
      chk("g_over", int'(game_state), 2);
      check_reset_now("rstOver");

      // start and hit together, hit persisting into the first running cycle
      start = 1'b1; hit = 1'b1; tick(); start = 1'b0;
      chk("h_state_run", int'(game_state), 1);
      tick(); hit = 1'b0;
      chk("h_state_over", int'(game_state), 2);
      chk("h_disp", int'(disp_value), 16'h0000);
      wait_idle();

      // Randomised play
      for (int i = 0; i < 3000; i++) begin
         start = ($urandom % 8) == 0;
         hit   = ($urandom % 32) == 0;
         tick();
      end
      start = 1'b0;
      hit = 1'b1; tick(); hit = 1'b0;
      wait_idle();

      // Long game: BCD carry across digits and saturation at 9999
      start = 1'b1; tick(); start = 1'b0;
      repeat (396) tick();
      chk("l_0099", int'(disp_value), 16'h0099);
      repeat (4) tick();
      chk("l_0100", int'(disp_value), 16'h0100);
      repeat (39596) tick();
      chk("l_9999", int'(disp_value), 16'h9999);
      repeat (4) tick();
      chk("l_sat", int'(disp_value), 16'h9999);
      hit = 1'b1; tick(); hit = 1'b0;
      chk("l_rec", int'(new_record), 1);
      wait_idle();
      chk("l_high", int'(disp_value), 16'h9999);

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/score_controller.md
Name: score_controller

Overview:
- Game-level sequencer for the 4-digit BCD score shown in the top-right HUD. It owns the run/score tick prescaler, the BCD score register and the high-score register.
- Runs a start / run / game-over flash / idle state machine driven by the player start button and the collision `hit` flag.
- Drives the BCD value and enable that feed the per-digit number renderers, replacing free-running score counting with a sequenced game flow.

Parameters:
- TICK_DIV, 20000000: clock cycles per score increment while running (min 2).
- BLINK_DIV, 12500000: clock cycles per blink phase in GAME_OVER (min 1).
- FLASH_PHASES, 6: number of blink phases in GAME_OVER before returning to IDLE (even, min 2).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled each cycle, acts only in IDLE.
- hit  in  1  level; collision flag, acts only in RUNNING.
- disp_value  out  16  BCD digits {thousands, hundreds, tens, units}, 4 bits each.
- disp_enable  out  1  digit renderers visible when 1 (blink control).
- running  out  1  high in RUNNING state.
- new_record  out  1  last finished game beat the previous high score.
- game_state  out  2  00 IDLE, 01 RUNNING, 10 GAME_OVER.

Behaviour:
- Reset (async, any state, including mid-run or mid-flash) sets:
  - state IDLE;
  - score, high, prescaler and blink counters to 0;
  - disp_value 0x0000, disp_enable 1, running 0, new_record 0.
- All outputs are registered. A state or register change made on edge N is visible on the outputs after edge N.
- IDLE:
  - disp_value = high score; disp_enable = 1.
  - start=1 → RUNNING; score cleared to 0000, prescaler cleared to 0, new_record cleared.
  - hit is ignored. start and hit asserted together: start wins.
- RUNNING:
  - disp_value = score; disp_enable = 1; running = 1.
  - Prescaler counts 0..TICK_DIV-1. On the cycle it equals TICK_DIV-1, it wraps to 0 and the score increments as BCD.
  - BCD increment: units 9 → 0 with carry into tens, and so on through thousands.
  - Score saturates at 9999: no further increment and no wrap to 0000.
  - start is ignored.
  - hit=1 → GAME_OVER on that edge. Priority rules:
    - a score tick falling on the same cycle is suppressed (hit wins);
    - the prescaler freezes;
    - score is held.
- GAME_OVER entry (same edge as the transition):
  - if score > high (BCD magnitude compare, strictly greater), high ← score and new_record ← 1;
  - otherwise high and new_record are unchanged;
  - blink counter cleared; phase count cleared; disp_enable ← 0.
- GAME_OVER:
  - disp_value = frozen score.
  - Every BLINK_DIV cycles, disp_enable toggles and the phase count increments.
  - When FLASH_PHASES phases have completed → IDLE with disp_enable = 1.
  - start and hit are ignored; new_record is held through IDLE until the next start.
- Equal score (score == high) does not set new_record.
- A hit present on the first RUNNING cycle after start ends the game with score 0000.
- game_state encoding 11 is unreachable. If it is ever entered, the FSM returns to IDLE on the next edge.

Test Plan (TICK_DIV=4, BLINK_DIV=3, FLASH_PHASES=4):
- Reset released, start pulsed 1 cycle → game_state=01, running=1, disp_value=0x0000. After 4×12 cycles disp_value=0x0012.
- Preload score to 0x0099 by running, then one further tick → 0x0100. From 0x9999 another tick → stays 0x9999.
- Assert hit on the same cycle as the prescaler terminal count with score 0x0007 → no increment. game_state=10, disp_value=0x0007, high=0x0007, new_record=1.
- In GAME_OVER: disp_enable sequence 0 for 3 cycles, 1, 0, 1 (3 cycles each). Then game_state=00, disp_enable=1, disp_value=0x0007. start held during the flash has no effect.
- Second game: end at 0x0005, then a third game ending at 0x0007 → new_record=0 both times, high stays 0x0007. A fourth game ending at 0x0008 → high=0x0008.
- Assert reset mid-RUNNING (score 0x0003) and mid-GAME_OVER → immediately game_state=00, disp_value=0x0000, high=0, disp_enable=1, new_record=0.
